// File: rtl/ralu_seq_pkg.sv
// Shared types and RALU control-field constants for the RALU microsequencer.
package ralu_seq_pkg;

  localparam int unsigned CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LDA  = 3'd1,
    LDB  = 3'd2,
    SHF  = 3'd3,
    WB   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU = 2'b00,
    OP_SHL = 2'b01,
    OP_SHR = 2'b10,
    OP_LDI = 2'b11
  } op_t;

  localparam logic [3:0] V_IDLE = 4'b0000;
  localparam logic [3:0] V_LDA  = 4'b0001;
  localparam logic [3:0] V_LDB  = 4'b0110;
  localparam logic [3:0] V_SHL  = 4'b0010;
  localparam logic [3:0] V_SHR  = 4'b0100;
  localparam logic [3:0] V_OUT  = 4'b1000;

endpackage

// File: rtl/ralu_seq.sv
// Microsequencer expanding one register-level command into the RALU control-pin
// pattern (load A, load B, shift, writeback) and capturing carry/shift status.
module ralu_seq
  import ralu_seq_pkg::*;
#(
  parameter int unsigned ADR_W    = 3,
  parameter logic [3:0]  PASS_B_S = 4'b1010,
  parameter logic        PASS_B_M = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ADR_W-1:0] cmd_ra,
  input  logic [ADR_W-1:0] cmd_rb,
  input  logic [ADR_W-1:0] cmd_rd,
  input  logic [3:0]       cmd_s,
  input  logic             cmd_m,
  input  logic             cmd_pin,
  input  logic [1:0]       cmd_cnt,
  input  logic             cmd_fill,
  input  logic             cmd_wr,
  input  logic             cmd_out,
  output logic             done,
  output logic             flag_c,
  output logic             flag_sh,
  output logic             ralu_a,
  output logic [3:0]       ralu_v,
  output logic [ADR_W-1:0] ralu_adr,
  output logic             ralu_wr,
  output logic [3:0]       ralu_s,
  output logic             ralu_m,
  output logic             ralu_pin,
  output logic             ralu_isl,
  output logic             ralu_isr,
  input  logic             ralu_pout,
  input  logic             ralu_osl,
  input  logic             ralu_osr
);

  state_t             state, state_nxt;
  op_t                op_q;
  logic [ADR_W-1:0]   ra_q, rb_q, rd_q;
  logic [3:0]         s_q;
  logic               m_q, pin_q, fill_q, wr_q, out_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               accept_c;
  op_t                op_c;
  logic [ADR_W-1:0]   ra_c, rb_c, rd_c;
  logic [3:0]         s_c;
  logic               m_c, pin_c, fill_c, wr_c, out_c;

  logic               a_c, wrp_c, mp_c, pinp_c, isl_c, isr_c;
  logic [3:0]         v_c, sp_c;
  logic [ADR_W-1:0]   adr_c;

  assign accept_c = cmd_valid && cmd_ready;

  // Effective command: the live inputs on the accept cycle, the latch otherwise.
  always_comb begin
    op_c   = accept_c ? op_t'(cmd_op) : op_q;
    ra_c   = accept_c ? cmd_ra   : ra_q;
    rb_c   = accept_c ? cmd_rb   : rb_q;
    rd_c   = accept_c ? cmd_rd   : rd_q;
    s_c    = accept_c ? cmd_s    : s_q;
    m_c    = accept_c ? cmd_m    : m_q;
    pin_c  = accept_c ? cmd_pin  : pin_q;
    fill_c = accept_c ? cmd_fill : fill_q;
    wr_c   = accept_c ? cmd_wr   : wr_q;
    out_c  = accept_c ? cmd_out  : out_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_c) state_nxt = (op_c == OP_ALU || op_c == OP_LDI) ? LDA : LDB;
      LDA:  state_nxt = (op_q == OP_LDI) ? WB : LDB;
      LDB:  state_nxt = (op_q == OP_ALU) ? WB : SHF;
      SHF:  if (cnt_q == 2'd0) state_nxt = WB;
      WB:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RALU pin decode from the state being entered, so pins line up with the state.
  always_comb begin
    a_c    = 1'b0;
    v_c    = V_IDLE;
    adr_c  = '0;
    wrp_c  = 1'b0;
    sp_c   = 4'b0000;
    mp_c   = 1'b0;
    pinp_c = 1'b0;
    isl_c  = 1'b0;
    isr_c  = 1'b0;
    case (state_nxt)
      LDA: begin
        adr_c = ra_c;
        v_c   = V_LDA;
        a_c   = (op_c == OP_LDI);
      end
      LDB: begin
        adr_c = rb_c;
        v_c   = V_LDB;
      end
      SHF: begin
        if (op_c == OP_SHL) begin
          v_c   = V_SHL;
          isl_c = fill_c;
        end else begin
          v_c   = V_SHR;
          isr_c = fill_c;
        end
      end
      WB: begin
        adr_c = rd_c;
        wrp_c = wr_c;
        v_c   = out_c ? V_OUT : V_IDLE;
        if (op_c == OP_SHL || op_c == OP_SHR) begin
          sp_c   = PASS_B_S;
          mp_c   = PASS_B_M;
          pinp_c = 1'b0;
        end else begin
          sp_c   = s_c;
          mp_c   = m_c;
          pinp_c = pin_c;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_ALU;
      ra_q      <= '0;
      rb_q      <= '0;
      rd_q      <= '0;
      s_q       <= '0;
      m_q       <= 1'b0;
      pin_q     <= 1'b0;
      fill_q    <= 1'b0;
      wr_q      <= 1'b0;
      out_q     <= 1'b0;
      cnt_q     <= '0;
      flag_c    <= 1'b0;
      flag_sh   <= 1'b0;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      ralu_a    <= 1'b0;
      ralu_v    <= V_IDLE;
      ralu_adr  <= '0;
      ralu_wr   <= 1'b0;
      ralu_s    <= '0;
      ralu_m    <= 1'b0;
      ralu_pin  <= 1'b0;
      ralu_isl  <= 1'b0;
      ralu_isr  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        op_q   <= op_t'(cmd_op);
        ra_q   <= cmd_ra;
        rb_q   <= cmd_rb;
        rd_q   <= cmd_rd;
        s_q    <= cmd_s;
        m_q    <= cmd_m;
        pin_q  <= cmd_pin;
        fill_q <= cmd_fill;
        wr_q   <= cmd_wr;
        out_q  <= cmd_out;
        cnt_q  <= cmd_cnt;
      end
      if (state == SHF) begin
        if (cnt_q != 2'd0) cnt_q <= cnt_q - 2'd1;
        flag_sh <= (op_q == OP_SHL) ? ralu_osl : ralu_osr;
      end
      if (state == WB && (op_q == OP_ALU || op_q == OP_LDI)) flag_c <= ralu_pout;
      cmd_ready <= (state_nxt == IDLE);
      done      <= (state == WB);
      ralu_a    <= a_c;
      ralu_v    <= v_c;
      ralu_adr  <= adr_c;
      ralu_wr   <= wrp_c;
      ralu_s    <= sp_c;
      ralu_m    <= mp_c;
      ralu_pin  <= pinp_c;
      ralu_isl  <= isl_c;
      ralu_isr  <= isr_c;
    end
  end

endmodule

// File: tb/tb_ralu_seq.sv
// Self-checking bench for ralu_seq: per-cycle RALU pin sequences, handshake and flags.
module tb_ralu_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_ra, cmd_rb, cmd_rd;
  logic [3:0] cmd_s;
  logic       cmd_m, cmd_pin;
  logic [1:0] cmd_cnt;
  logic       cmd_fill, cmd_wr, cmd_out;
  logic       done, flag_c, flag_sh;
  logic       ralu_a;
  logic [3:0] ralu_v;
  logic [2:0] ralu_adr;
  logic       ralu_wr;
  logic [3:0] ralu_s;
  logic       ralu_m, ralu_pin, ralu_isl, ralu_isr;
  logic       ralu_pout, ralu_osl, ralu_osr;

  ralu_seq dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_s(cmd_s), .cmd_m(cmd_m), .cmd_pin(cmd_pin), .cmd_cnt(cmd_cnt),
    .cmd_fill(cmd_fill), .cmd_wr(cmd_wr), .cmd_out(cmd_out),
    .done(done), .flag_c(flag_c), .flag_sh(flag_sh),
    .ralu_a(ralu_a), .ralu_v(ralu_v), .ralu_adr(ralu_adr), .ralu_wr(ralu_wr),
    .ralu_s(ralu_s), .ralu_m(ralu_m), .ralu_pin(ralu_pin),
    .ralu_isl(ralu_isl), .ralu_isr(ralu_isr),
    .ralu_pout(ralu_pout), .ralu_osl(ralu_osl), .ralu_osr(ralu_osr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       a;
    logic [3:0] v;
    logic [2:0] adr;
    logic       wr;
    logic [3:0] s;
    logic       m;
    logic       pin;
    logic       isl;
    logic       isr;
  } pins_t;

  typedef struct {
    logic [1:0] op;
    logic [2:0] ra, rb, rd;
    logic [3:0] s;
    logic       m, pin;
    logic [1:0] cnt;
    logic       fill, wr, out;
  } cmd_t;

  int    checks = 0;
  int    fails  = 0;
  int    wr_seen = 0;
  logic  m_fc = 1'b0;
  logic  m_fs = 1'b0;
  pins_t exp_q[$];

  always @(negedge clk) if (ralu_wr === 1'b1) wr_seen++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic pins_t obs_pins();
    pins_t p;
    p = {ralu_a, ralu_v, ralu_adr, ralu_wr, ralu_s, ralu_m, ralu_pin, ralu_isl, ralu_isr};
    return p;
  endfunction

  // Reference: the list of control-pin phases a command must produce, one per busy cycle.
  function automatic void build_expect(input cmd_t c);
    pins_t p;
    bit shift;
    shift = (c.op == 2'b01) || (c.op == 2'b10);
    exp_q.delete();
    if (!shift) begin
      p = '0; p.adr = c.ra; p.v = 4'b0001; p.a = (c.op == 2'b11);
      exp_q.push_back(p);
    end
    if (c.op != 2'b11) begin
      p = '0; p.adr = c.rb; p.v = 4'b0110;
      exp_q.push_back(p);
    end
    if (shift) begin
      for (int k = 0; k <= int'(c.cnt); k++) begin
        p = '0;
        if (c.op == 2'b01) begin p.v = 4'b0010; p.isl = c.fill; end
        else               begin p.v = 4'b0100; p.isr = c.fill; end
        exp_q.push_back(p);
      end
    end
    p = '0; p.adr = c.rd; p.wr = c.wr; p.v = c.out ? 4'b1000 : 4'b0000;
    if (shift) begin p.s = 4'b1010; p.m = 1'b1; p.pin = 1'b0; end
    else       begin p.s = c.s;     p.m = c.m;  p.pin = c.pin; end
    exp_q.push_back(p);
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.op = 2'($urandom); c.ra = 3'($urandom); c.rb = 3'($urandom); c.rd = 3'($urandom);
    c.s = 4'($urandom); c.m = 1'($urandom); c.pin = 1'($urandom); c.cnt = 2'($urandom);
    c.fill = 1'($urandom); c.wr = 1'($urandom); c.out = 1'($urandom);
    return c;
  endfunction

  task automatic garble_inputs();
    cmd_valid = 1'($urandom);
    cmd_op = 2'($urandom); cmd_ra = 3'($urandom); cmd_rb = 3'($urandom); cmd_rd = 3'($urandom);
    cmd_s = 4'($urandom); cmd_m = 1'($urandom); cmd_pin = 1'($urandom); cmd_cnt = 2'($urandom);
    cmd_fill = 1'($urandom); cmd_wr = 1'($urandom); cmd_out = 1'($urandom);
  endtask

  // Called at posedge+1 with the sequencer ready; returns at posedge+1 of the done cycle.
  task automatic run_cmd(input cmd_t c, input string tag);
    int  n, wr0;
    bit  shift;
    chk({tag, "_ready_pre"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op = c.op; cmd_ra = c.ra; cmd_rb = c.rb; cmd_rd = c.rd; cmd_s = c.s;
    cmd_m = c.m; cmd_pin = c.pin; cmd_cnt = c.cnt; cmd_fill = c.fill;
    cmd_wr = c.wr; cmd_out = c.out;
    build_expect(c);
    n = exp_q.size();
    shift = (c.op == 2'b01) || (c.op == 2'b10);
    wr0 = wr_seen;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_pins%0d", tag, i), 32'(obs_pins()), 32'(exp_q[i]));
      chk($sformatf("%s_busy%0d", tag, i), {30'd0, cmd_ready, done}, 32'd0);
      garble_inputs();
      ralu_pout = 1'($urandom); ralu_osl = 1'($urandom); ralu_osr = 1'($urandom);
      if (i == n - 1 && !shift) m_fc = ralu_pout;
      if (shift && i >= 1 && i < n - 1) m_fs = (c.op == 2'b01) ? ralu_osl : ralu_osr;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready_done"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_pins_idle"}, 32'(obs_pins()), 32'd0);
    chk({tag, "_flag_c"}, 32'(flag_c), 32'(m_fc));
    chk({tag, "_flag_sh"}, 32'(flag_sh), 32'(m_fs));
    chk({tag, "_wr_count"}, 32'(wr_seen - wr0), 32'(c.wr));
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    chk({tag, "_idle_done"}, 32'(done), 32'd0);
    chk({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_idle_pins"}, 32'(obs_pins()), 32'd0);
  endtask

  initial begin
    cmd_t c;
    int   wr0;
    reset = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rd = '0; cmd_s = '0;
    cmd_m = 1'b0; cmd_pin = 1'b0; cmd_cnt = '0; cmd_fill = 1'b0; cmd_wr = 1'b0; cmd_out = 1'b0;
    ralu_pout = 1'b0; ralu_osl = 1'b0; ralu_osr = 1'b0;
    #12;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pins", 32'(obs_pins()), 32'd0);
    chk("rst_flags", {30'd0, flag_c, flag_sh}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle("post_rst");

    // Load immediate into r1, then add r1+r1 into r2 with Rout, then another add.
    c = '{op:2'b11, ra:3'd0, rb:3'd0, rd:3'd1, s:4'b1111, m:1'b1, pin:1'b0, cnt:2'd0, fill:1'b0, wr:1'b1, out:1'b0};
    run_cmd(c, "ldi");
    c = '{op:2'b00, ra:3'd1, rb:3'd1, rd:3'd2, s:4'b1001, m:1'b0, pin:1'b0, cnt:2'd0, fill:1'b0, wr:1'b1, out:1'b1};
    run_cmd(c, "add");
    c = '{op:2'b00, ra:3'd4, rb:3'd4, rd:3'd5, s:4'b1001, m:1'b0, pin:1'b0, cnt:2'd3, fill:1'b1, wr:1'b1, out:1'b0};
    run_cmd(c, "add99");
    idle_cycle("gap1");

    c = '{op:2'b01, ra:3'd7, rb:3'd3, rd:3'd3, s:4'b0000, m:1'b0, pin:1'b1, cnt:2'd2, fill:1'b1, wr:1'b1, out:1'b0};
    run_cmd(c, "shl3");
    c = '{op:2'b10, ra:3'd0, rb:3'd6, rd:3'd6, s:4'b0101, m:1'b0, pin:1'b0, cnt:2'd0, fill:1'b0, wr:1'b1, out:1'b1};
    run_cmd(c, "shr1");
    c = '{op:2'b01, ra:3'd2, rb:3'd2, rd:3'd2, s:4'b0000, m:1'b0, pin:1'b0, cnt:2'd3, fill:1'b0, wr:1'b0, out:1'b0};
    run_cmd(c, "shl4_nowr");
    idle_cycle("gap2");

    // Back-to-back: second command offered in the done cycle of the first.
    run_cmd(rand_cmd(), "b2b_a");
    run_cmd(rand_cmd(), "b2b_b");
    run_cmd(rand_cmd(), "b2b_c");
    idle_cycle("gap3");

    // Reset while an ALU command sits in its LDB phase.
    c = '{op:2'b00, ra:3'd3, rb:3'd5, rd:3'd6, s:4'b1001, m:1'b0, pin:1'b1, cnt:2'd0, fill:1'b0, wr:1'b1, out:1'b1};
    cmd_valid = 1'b1;
    cmd_op = c.op; cmd_ra = c.ra; cmd_rb = c.rb; cmd_rd = c.rd; cmd_s = c.s;
    cmd_m = c.m; cmd_pin = c.pin; cmd_cnt = c.cnt; cmd_fill = c.fill; cmd_wr = c.wr; cmd_out = c.out;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("mid_ldb_v", 32'(ralu_v), 32'h6);
    chk("mid_ldb_adr", 32'(ralu_adr), 32'(c.rb));
    wr0 = wr_seen;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_pins", 32'(obs_pins()), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_flags", {30'd0, flag_c, flag_sh}, 32'd0);
    m_fc = 1'b0; m_fs = 1'b0;
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) idle_cycle($sformatf("after_rst%0d", i));
    chk("after_rst_no_wr", 32'(wr_seen - wr0), 32'd0);

    // Randomized commands with optional idle gaps.
    for (int k = 0; k < 40; k++) begin
      run_cmd(rand_cmd(), $sformatf("rnd%0d", k));
      if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rnd_gap%0d", k));
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
